// File: rtl/stuff_or_data_sched.sv
// Stuff/data slot scheduler.
// Each accepted sof header starts a frame of pm slots. The cm data slots are
// spread evenly across the frame with a Bresenham-style accumulator. The
// block also checks headers and sof sequencing, and reports end-of-frame and
// the slot index. Every output is registered.
module stuff_or_data_sched #(
  parameter int MPT_W      = 8,
  parameter bit STUFF_LAST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MPT_W-1:0] pm,
  input  logic [MPT_W-1:0] cm,
  input  logic             valid_in,
  input  logic             sof,
  output logic             sof_out,
  output logic             valid_out,
  output logic             ds,
  output logic             eof_out,
  output logic [MPT_W-1:0] slot_idx,
  output logic             input_err,
  output logic             err_sof_early,
  output logic             err_sof_late
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [MPT_W:0] ACC_ONE = {{MPT_W{1'b0}}, 1'b1};

  state_t           state_r;
  logic [MPT_W:0]   acc_r;     // one extra bit so acc + cm cannot wrap at pm = 2^MPT_W-1
  logic [MPT_W-1:0] counter_r;
  logic [MPT_W-1:0] pm_r;
  logic [MPT_W-1:0] cm_r;

  logic             hdr_ok_s;
  logic [MPT_W:0]   acc_init_s;
  logic [MPT_W:0]   sum_s;
  logic             take_s;
  logic [MPT_W:0]   acc_next_s;
  logic [MPT_W:0]   cnt_ext_s;
  logic             last_s;

  // Header check, accumulator step and end-of-frame detection.
  always_comb begin
    hdr_ok_s   = 1'b0;
    acc_init_s = '0;
    sum_s      = '0;
    take_s     = 1'b0;
    acc_next_s = '0;
    cnt_ext_s  = '0;
    last_s     = 1'b0;

    hdr_ok_s = (pm != '0) && (cm <= pm);
    // Reverse placement starts the accumulator one short of a full period.
    // This time-reverses the pattern of each frame.
    if (STUFF_LAST) begin
      acc_init_s = {1'b0, pm} - ACC_ONE;
    end else begin
      acc_init_s = '0;
    end

    sum_s  = acc_r + {1'b0, cm_r};
    take_s = (sum_s >= {1'b0, pm_r});
    if (take_s) begin
      acc_next_s = sum_s - {1'b0, pm_r};
    end else begin
      acc_next_s = sum_s;
    end

    // The comparison is one bit wider, so it happens before the counter can wrap.
    cnt_ext_s = {1'b0, counter_r} + ACC_ONE;
    last_s    = (cnt_ext_s == {1'b0, pm_r});
  end

  // Frame state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      acc_r         <= '0;
      counter_r     <= '0;
      pm_r          <= '0;
      cm_r          <= '0;
      sof_out       <= 1'b0;
      valid_out     <= 1'b0;
      ds            <= 1'b0;
      eof_out       <= 1'b0;
      slot_idx      <= '0;
      input_err     <= 1'b0;
      err_sof_early <= 1'b0;
      err_sof_late  <= 1'b0;
    end else begin
      sof_out       <= 1'b0;
      valid_out     <= 1'b0;
      ds            <= 1'b0;
      eof_out       <= 1'b0;
      input_err     <= 1'b0;
      err_sof_early <= 1'b0;
      err_sof_late  <= 1'b0;

      case (state_r)
        IDLE: begin
          if (sof) begin
            // A header beat never counts as a slot, even when valid_in is high.
            if (hdr_ok_s) begin
              pm_r      <= pm;
              cm_r      <= cm;
              acc_r     <= acc_init_s;
              counter_r <= '0;
              sof_out   <= 1'b1;
              state_r   <= RUN;
            end else begin
              input_err <= 1'b1;
              state_r   <= IDLE;
            end
          end else if (valid_in) begin
            err_sof_late <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end

        RUN: begin
          if (sof) begin
            // sof during a frame aborts that frame without an eof.
            // The new header is then judged as if the block were idle.
            err_sof_early <= 1'b1;
            if (hdr_ok_s) begin
              pm_r      <= pm;
              cm_r      <= cm;
              acc_r     <= acc_init_s;
              counter_r <= '0;
              sof_out   <= 1'b1;
              state_r   <= RUN;
            end else begin
              input_err <= 1'b1;
              state_r   <= IDLE;
            end
          end else if (valid_in) begin
            acc_r     <= acc_next_s;
            counter_r <= cnt_ext_s[MPT_W-1:0];
            slot_idx  <= cnt_ext_s[MPT_W-1:0];
            valid_out <= 1'b1;
            ds        <= take_s;
            if (last_s) begin
              eof_out <= 1'b1;
              state_r <= IDLE;
            end else begin
              state_r <= RUN;
            end
          end else begin
            // A gap beat: hold all state.
            state_r <= RUN;
          end
        end

        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stuff_or_data_sched.sv
// Table-driven bench for stuff_or_data_sched.
// Two DUTs share the same inputs: one places data slots last (forward
// placement), the other time-reverses the pattern. Vector records are built
// from a closed-form reference. The expected ds for slot k is
// floor(k*cm/pm) - floor((k-1)*cm/pm), mirrored in k for the reversed DUT.
// Each record is queued on drive and popped one cycle later for comparison.
module tb_stuff_or_data_sched;

  typedef struct {
    logic       sof;
    logic       vin;
    logic [7:0] pm;
    logic [7:0] cm;
    logic       e_sof_out;
    logic       e_vout;
    logic       e_ds;
    logic       e_rds;
    logic       e_eof;
    logic [7:0] e_idx;
    logic       e_ierr;
    logic       e_early;
    logic       e_late;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pm = 8'd0;
  logic [7:0] cm = 8'd0;
  logic       valid_in = 1'b0;
  logic       sof = 1'b0;

  logic       sof_out, valid_out, ds, eof_out, input_err, err_sof_early, err_sof_late;
  logic [7:0] slot_idx;
  logic       r_sof_out, r_valid_out, r_ds, r_eof_out, r_input_err, r_err_sof_early, r_err_sof_late;
  logic [7:0] r_slot_idx;

  vec_t tbl[$];
  vec_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int ds_cnt = 0;
  int rds_cnt = 0;

  // reference model state used while building tables
  bit m_run = 1'b0;
  int m_pm = 0;
  int m_cm = 0;
  int m_k = 0;
  int m_idx = 0;

  stuff_or_data_sched #(.MPT_W(8), .STUFF_LAST(1'b0)) u_fwd (
    .clk(clk), .rst_n(rst_n), .pm(pm), .cm(cm), .valid_in(valid_in), .sof(sof),
    .sof_out(sof_out), .valid_out(valid_out), .ds(ds), .eof_out(eof_out),
    .slot_idx(slot_idx), .input_err(input_err), .err_sof_early(err_sof_early),
    .err_sof_late(err_sof_late)
  );

  stuff_or_data_sched #(.MPT_W(8), .STUFF_LAST(1'b1)) u_rev (
    .clk(clk), .rst_n(rst_n), .pm(pm), .cm(cm), .valid_in(valid_in), .sof(sof),
    .sof_out(r_sof_out), .valid_out(r_valid_out), .ds(r_ds), .eof_out(r_eof_out),
    .slot_idx(r_slot_idx), .input_err(r_input_err), .err_sof_early(r_err_sof_early),
    .err_sof_late(r_err_sof_late)
  );

  always #5 clk = ~clk;

  function automatic int fwd_d(input int k, input int p, input int c);
    return ((k * c) / p) - (((k - 1) * c) / p);
  endfunction

  // Append one vector. Off-header beats carry random pm/cm that must be ignored.
  task automatic v(input logic s, input logic vi, input int p, input int c, input string nm);
    vec_t r;
    int pp;
    int cc;
    pp = s ? p : int'($urandom_range(0, 255));
    cc = s ? c : int'($urandom_range(0, 255));
    r.sof = s; r.vin = vi; r.pm = pp[7:0]; r.cm = cc[7:0];
    r.e_sof_out = 1'b0; r.e_vout = 1'b0; r.e_ds = 1'b0; r.e_rds = 1'b0; r.e_eof = 1'b0;
    r.e_ierr = 1'b0; r.e_early = 1'b0; r.e_late = 1'b0; r.name = nm;
    if (s) begin
      if (m_run) r.e_early = 1'b1;
      if (p != 0 && c <= p) begin
        r.e_sof_out = 1'b1; m_run = 1'b1; m_pm = p; m_cm = c; m_k = 0;
      end else begin
        r.e_ierr = 1'b1; m_run = 1'b0;
      end
    end else if (vi) begin
      if (!m_run) begin
        r.e_late = 1'b1;
      end else begin
        m_k = m_k + 1;
        r.e_vout = 1'b1;
        r.e_ds = fwd_d(m_k, m_pm, m_cm) != 0;
        r.e_rds = fwd_d(m_pm + 1 - m_k, m_pm, m_cm) != 0;
        m_idx = m_k;
        if (m_k == m_pm) begin
          r.e_eof = 1'b1; m_run = 1'b0;
        end
      end
    end
    r.e_idx = m_idx[7:0];
    tbl.push_back(r);
  endtask

  task automatic slots(input int n, input string nm);
    for (int i = 0; i < n; i++) v(1'b0, 1'b1, 0, 0, nm);
  endtask

  task automatic apply_table();
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      sof = tbl[i].sof; valid_in = tbl[i].vin; pm = tbl[i].pm; cm = tbl[i].cm;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if (valid_out) ds_cnt++;
      if (r_valid_out && r_ds) rds_cnt++;
      if (valid_out && ds) ds_cnt += 1000;
      if ({sof_out, valid_out, ds, r_ds, eof_out, slot_idx, input_err, err_sof_early, err_sof_late} !==
          {e.e_sof_out, e.e_vout, e.e_ds, e.e_rds, e.e_eof, e.e_idx, e.e_ierr, e.e_early, e.e_late}) begin
        n_err++;
        $display("FAIL %s vec %0d: got sof_out=%b vout=%b ds=%b rds=%b eof=%b idx=%0d ierr=%b early=%b late=%b; want %b %b %b %b %b %0d %b %b %b",
                 e.name, i, sof_out, valid_out, ds, r_ds, eof_out, slot_idx, input_err, err_sof_early, err_sof_late,
                 e.e_sof_out, e.e_vout, e.e_ds, e.e_rds, e.e_eof, e.e_idx, e.e_ierr, e.e_early, e.e_late);
      end
    end
    tbl.delete();
    sof = 1'b0; valid_in = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    n_vec++;
    if ({sof_out, valid_out, ds, eof_out, slot_idx, input_err, err_sof_early, err_sof_late,
         r_sof_out, r_valid_out, r_ds, r_eof_out, r_slot_idx, r_input_err, r_err_sof_early, r_err_sof_late} !== '0) begin
      n_err++;
      $display("FAIL %s: got vout=%b ds=%b eof=%b idx=%0d sof_out=%b (rev vout=%b idx=%0d), want all 0",
               nm, valid_out, ds, eof_out, slot_idx, sof_out, r_valid_out, r_slot_idx);
    end
  endtask

  initial begin
    // reset state
    #12;
    check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // phase 1: functional frames
    v(1'b0, 1'b0, 0, 0, "idle");
    v(1'b1, 1'b1, 5, 2, "hdr_5_2");
    slots(5, "f_5_2");
    v(1'b1, 1'b0, 4, 4, "hdr_4_4_b2b");
    slots(4, "f_4_4");
    v(1'b1, 1'b0, 3, 0, "hdr_3_0_b2b");
    slots(3, "f_3_0");
    v(1'b0, 1'b0, 0, 0, "idle2");
    v(1'b1, 1'b0, 5, 6, "hdr_cm_gt_pm");
    v(1'b0, 1'b0, 0, 0, "idle3");
    v(1'b1, 1'b0, 0, 3, "hdr_pm0");
    v(1'b0, 1'b1, 0, 0, "late");
    v(1'b1, 1'b0, 7, 3, "hdr_7_3");
    for (int i = 0; i < 19; i++) v(1'b0, (i % 3) == 0, 0, 0, "gaps_7_3");
    v(1'b0, 1'b0, 0, 0, "idle4");
    v(1'b1, 1'b0, 6, 2, "hdr_6_2");
    slots(2, "f_6_2_part");
    v(1'b1, 1'b1, 4, 1, "hdr_early_4_1");
    slots(4, "f_4_1");
    v(1'b1, 1'b0, 5, 5, "hdr_5_5");
    slots(1, "f_5_5_part");
    v(1'b1, 1'b0, 0, 0, "hdr_bad_in_run");
    v(1'b0, 1'b1, 0, 0, "late_after_abort");
    v(1'b1, 1'b0, 6, 3, "hdr_6_3");
    slots(2, "f_6_3_part");
    apply_table();

    // asynchronous reset between edges, mid-frame
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    #9;
    rst_n = 1'b1;
    m_run = 1'b0; m_idx = 0;
    @(posedge clk);
    #1;

    // phase 2: post-reset late strobe, then full-width frame
    ds_cnt = 0; rds_cnt = 0;
    v(1'b0, 1'b1, 0, 0, "late_after_reset");
    v(1'b1, 1'b0, 255, 254, "hdr_255_254");
    slots(255, "f_255_254");
    v(1'b0, 1'b0, 0, 0, "idle_end");
    apply_table();

    // ds_cnt counts valid slots + 1000 per data slot on the forward DUT
    n_vec++;
    if (ds_cnt != 255 + 254 * 1000) begin
      n_err++;
      $display("FAIL total_255: got %0d slots/%0d data, want 255/254", ds_cnt % 1000, ds_cnt / 1000);
    end
    n_vec++;
    if (rds_cnt != 254) begin
      n_err++;
      $display("FAIL total_rev_255: got %0d data slots, want 254", rds_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
